// File: rtl/seq_pkg.sv
// Shared types and constants for the PC sequencer and its offset LUT.
// State encoding, LUT geometry and a counter-width helper live here.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_HALTED = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam int LUT_DEPTH = 8;
    localparam int LUT_AW    = $clog2(LUT_DEPTH);

    // Bits needed to hold values 0..n inclusive, never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) <= n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Eight-entry branch-offset table with one write port and one read port.
// Reads are combinational, so a same-cycle write is seen from the next cycle.
module branch_lut
    import seq_pkg::*;
#(
    parameter int D = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [LUT_AW-1:0] waddr,
    input  logic [D-1:0]      wdata,
    input  logic [LUT_AW-1:0] raddr,
    output logic [D-1:0]      rdata
);

    logic [D-1:0] mem [LUT_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: drives instruction fetch, PC advance and
// relative jumps, counts retired instructions and traps fetch timeouts.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int D   = 12,
    parameter int TMO = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              imem_valid,
    input  logic              dec_branch,
    input  logic              dec_halt,
    input  logic              cond_true,
    input  logic [LUT_AW-1:0] lut_idx,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [D-1:0]      lut_wdata,
    output logic              imem_req,
    output logic              pc_req,
    output logic              pc_reljump_en,
    output logic [D-1:0]      pc_offset,
    output logic [15:0]       retired,
    output logic              done,
    output logic              fault
);

    localparam int WW = cnt_width(TMO);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TMO - 1);

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [15:0]   retired_q;
    logic [D-1:0]  lut_rdata;
    logic          taken;

    branch_lut #(
        .D(D)
    ) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (lut_idx),
        .rdata (lut_rdata)
    );

    assign taken   = dec_branch & cond_true;
    assign retired = retired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            retired_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        state <= S_EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_EXEC: begin
                    retired_q <= retired_q + 16'd1;
                    if (dec_halt) begin
                        state <= S_HALTED;
                    end else begin
                        state    <= S_FETCH;
                        wait_cnt <= '0;
                    end
                end
                S_HALTED: state <= S_HALTED;
                S_FAULT:  state <= S_FAULT;
                default:  state <= S_FAULT;
            endcase
        end
    end

    // Outputs follow state and inputs directly; reset masks them at once.
    always_comb begin
        imem_req      = 1'b0;
        pc_req        = 1'b0;
        pc_reljump_en = 1'b0;
        pc_offset     = '0;
        done          = 1'b0;
        fault         = 1'b0;
        if (!reset) begin
            unique case (state)
                S_FETCH: imem_req = 1'b1;
                S_EXEC: begin
                    if (!dec_halt) begin
                        pc_req = 1'b1;
                        if (taken) begin
                            pc_reljump_en = 1'b1;
                            pc_offset     = lut_rdata;
                        end
                    end
                end
                S_HALTED: done  = 1'b1;
                S_FAULT:  fault = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter D, default 12, meaning program-counter and offset width.
REQ-002 SHALL have parameter TMO, default 15, meaning the maximum FETCH wait cycles before fault.
REQ-003 SHALL have port: clk  input  1  the single clock; all state changes on posedge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  begins execution from IDLE.
REQ-006 SHALL have port: imem_valid  input  1  instruction memory has returned the word for the current PC.
REQ-007 SHALL have port: dec_branch  input  1  decoded instruction is a relative branch.
REQ-008 SHALL have port: dec_halt  input  1  decoded instruction is halt.
REQ-009 SHALL have port: cond_true  input  1  branch condition flag from the ALU.
REQ-010 SHALL have port: lut_idx  input  3  branch-offset LUT read index.
REQ-011 SHALL have port: lut_we  input  1  LUT write enable.
REQ-012 SHALL have port: lut_waddr  input  3  LUT write index.
REQ-013 SHALL have port: lut_wdata  input  D  LUT write data.
REQ-014 SHALL have port: imem_req  output  1  fetch request to instruction memory.
REQ-015 SHALL have port: pc_req  output  1  PC advance strobe.
REQ-016 SHALL have port: pc_reljump_en  output  1  PC relative-jump enable.
REQ-017 SHALL have port: pc_offset  output  D  PC jump offset.
REQ-018 SHALL have port: retired  output  16  count of executed instructions.
REQ-019 SHALL have ports: done  output  1  halted; fault  output  1  fetch timeout.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH, EXEC, HALTED, FAULT.
REQ-021 IDLE SHALL go to FETCH on start=1 and otherwise hold; start SHALL be ignored in every other state.
REQ-022 FETCH SHALL assert imem_req=1 and go to EXEC in the cycle after imem_valid=1 is sampled.
REQ-023 FETCH SHALL count cycles without imem_valid, and reaching TMO such cycles SHALL go to FAULT.
REQ-024 The FETCH wait counter SHALL clear on every entry to FETCH.
REQ-025 EXEC SHALL last exactly one cycle and assert pc_req=1 unless dec_halt=1.
REQ-026 In EXEC with dec_branch=1 and cond_true=1, pc_reljump_en SHALL be 1 and pc_offset SHALL be LUT[lut_idx].
REQ-027 In EXEC otherwise, pc_reljump_en SHALL be 0 and pc_offset SHALL be 0 (PC +1).
REQ-028 A taken branch whose LUT entry is 0 SHALL still be driven with pc_reljump_en=1, and the PC then increments by 1.
REQ-029 EXEC with dec_halt=1 SHALL assert pc_req=0 and go to HALTED; dec_halt SHALL take priority over dec_branch.
REQ-030 EXEC without halt SHALL go to FETCH.
REQ-031 retired SHALL increment by 1 on every EXEC cycle, halt included, and SHALL wrap from 0xFFFF to 0.
REQ-032 HALTED SHALL drive done=1 and FAULT SHALL drive fault=1, and both states SHALL be left only by reset.
REQ-033 All outputs other than those named for a state SHALL be 0 in that state; outputs SHALL be combinational from state and inputs.
REQ-034 The LUT SHALL have 8 entries of D bits, written on posedge when lut_we=1, in any state.
REQ-035 A LUT write and read of the same index in the same cycle SHALL return the old value, with the new value visible next cycle.

Reset
REQ-036 reset=1 SHALL immediately force IDLE, clear the wait counter, set retired=0, and clear all LUT entries to 0, including mid-FETCH or mid-EXEC.
REQ-037 While reset=1, all outputs SHALL be 0.

Structure
REQ-038 The state enum and the LUT depth constant (8) SHALL live in shared package seq_pkg.
REQ-039 The offset LUT SHALL be sub-module branch_lut; the FSM and counters SHALL remain in pc_sequencer.

Verification
REQ-040 Test: reset, then start, then imem_valid after 2 cycles, dec_branch=0 -> imem_req high for 3 cycles, one pc_req with reljump_en=0, retired=1.
REQ-041 Test: LUT[3]=0x7FD, then EXEC with dec_branch=1, cond_true=1, lut_idx=3 -> pc_reljump_en=1, pc_offset=0x7FD; with cond_true=0 -> offset 0, reljump_en=0.
REQ-042 Test: imem_valid held 0 for 15 cycles in FETCH -> fault=1, and state stays FAULT until reset.
REQ-043 Test: dec_halt=1 together with dec_branch=1 -> pc_req=0, done=1 next cycle, and retired increments.
REQ-044 Test: lut_we to index 5 with 0x010 while reading index 5 -> old value 0 that cycle, 0x010 the next.
REQ-045 Test: assert reset asynchronously mid-FETCH -> outputs 0 without waiting for a clock edge, and IDLE, retired=0 after release.
